poly_memory_pingpong: RTL and testbench

- Double-buffered operand memory for the AMNS multiplier.
- Loads a full operand set (A, B, M, M_prime; 4*N*S words) from a single-port BRAM into a shadow bank while the datapath reads the active bank.
- Writes result words back to BRAM. Load and store share the BRAM port through a one-deep request queue; BRAM read latency is a parameter.

---
 rtl/poly_memory_pingpong.sv | 266 ++++++++++++++++++++++++++
 tb/tb_poly_memory_pingpong.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_memory_pingpong.sv
// poly_memory_pingpong: double-buffered operand memory for the AMNS multiplier.
// An operand set (A, B, M, M_prime) streams from a single-port BRAM into the
// shadow bank while the datapath reads the active bank. Result words are
// written back through the same BRAM port.
// Optional build macro POLY_MEMORY_CHECKSUM_EN adds load_checksum_o, the XOR
// of every word written into the shadow bank by the most recent load.
module poly_memory_pingpong #(
  parameter int WORD_WIDTH = 17,
  parameter int N          = 5,
  parameter int S          = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int BRAM_LAT   = 1,
  localparam int L  = 4 * N * S,
  localparam int R  = N * S,
  localparam int RA = $clog2(L)
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    load_start_i,
  input  logic [ADDR_WIDTH-1:0]   load_base_i,
  input  logic                    store_start_i,
  input  logic [ADDR_WIDTH-1:0]   store_base_i,
  input  logic [R*WORD_WIDTH-1:0] res_din_i,
  input  logic                    swap_i,
  input  logic [RA-1:0]           rd_addr_i,
  input  logic [WORD_WIDTH-1:0]   BRAM_dout_i,
  output logic                    BRAM_en_o,
  output logic                    BRAM_we_o,
  output logic [ADDR_WIDTH-1:0]   BRAM_addr_o,
  output logic [WORD_WIDTH-1:0]   BRAM_din_o,
  output logic [WORD_WIDTH-1:0]   rd_data_o,
  output logic                    active_bank_o,
  output logic                    shadow_valid_o,
  output logic                    busy_o,
  output logic                    swap_err_o,
  output logic                    load_done_o,
  output logic                    store_done_o
`ifdef POLY_MEMORY_CHECKSUM_EN
  ,
  output logic [WORD_WIDTH-1:0]   load_checksum_o
`endif
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] LOAD_ISSUE = 2'd1;
  localparam logic [1:0] LOAD_DRAIN = 2'd2;
  localparam logic [1:0] STORE      = 2'd3;

  localparam logic [RA-1:0]         LOAD_LAST  = RA'(L - 1);
  localparam logic [RA-1:0]         DRAIN_LAST = RA'(BRAM_LAT);
  localparam logic [RA-1:0]         STORE_LAST = RA'(R - 1);
  localparam logic [RA-1:0]         CNT_ONE    = RA'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

  logic [1:0]              state_reg;
  logic [RA-1:0]           cnt_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [R*WORD_WIDTH-1:0] shift_reg;
  logic                    load_pend_reg;
  logic                    store_pend_reg;
  logic [ADDR_WIDTH-1:0]   load_base_reg;
  logic [ADDR_WIDTH-1:0]   store_base_reg;
  logic [R*WORD_WIDTH-1:0] store_data_reg;
  logic                    active_reg;
  logic                    shadow_valid_reg;
  logic                    load_done_reg;
  logic                    store_done_reg;
  logic                    swap_err_reg;
  logic [BRAM_LAT-1:0]     vld_pipe_reg;
  logic                    cap_valid_reg;
  logic [WORD_WIDTH-1:0]   cap_data_reg;
  logic [RA-1:0]           wr_idx_reg;
  logic [WORD_WIDTH-1:0]   rd_data_reg;

  // Both banks share one array; the bank index is the top address bit.
  logic [WORD_WIDTH-1:0]   mem [2**(RA+1)];

  logic                    load_take;
  logic                    store_take;
  logic                    load_want;
  logic                    store_want;
  logic                    at_exit;
  logic                    go_store;
  logic                    go_load;
  logic                    issuing;
  logic                    swap_ok;
  logic [ADDR_WIDTH-1:0]   load_base_next;
  logic [ADDR_WIDTH-1:0]   store_base_next;
  logic [R*WORD_WIDTH-1:0] store_data_next;

  // Request acceptance, dispatch arbitration (store wins) and swap qualification.
  always_comb begin
    load_take       = load_start_i && !load_pend_reg;
    store_take      = store_start_i && !store_pend_reg;
    load_base_next  = load_take  ? load_base_i  : load_base_reg;
    store_base_next = store_take ? store_base_i : store_base_reg;
    store_data_next = store_take ? res_din_i    : store_data_reg;
    at_exit = ((state_reg == LOAD_DRAIN) && (cnt_reg == DRAIN_LAST)) ||
              ((state_reg == STORE) && (cnt_reg == STORE_LAST));
    // A fresh start is only dispatched straight from IDLE; at the end of an
    // operation only requests that were already pending are considered.
    if (state_reg == IDLE) begin
      store_want = store_pend_reg || store_take;
      load_want  = load_pend_reg || load_take;
    end else begin
      store_want = store_pend_reg && at_exit;
      load_want  = load_pend_reg && at_exit;
    end
    go_store = store_want;
    go_load  = load_want && !store_want;
    issuing  = (state_reg == LOAD_ISSUE);
    swap_ok  = swap_i && shadow_valid_reg && !issuing && (state_reg != LOAD_DRAIN) &&
               !load_pend_reg && !load_done_reg;
  end

  // Pending request flags with their latched base addresses and result data.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      load_pend_reg  <= 1'b0;
      store_pend_reg <= 1'b0;
      load_base_reg  <= '0;
      store_base_reg <= '0;
      store_data_reg <= '0;
    end else begin
      load_pend_reg  <= (load_pend_reg || load_take) && !go_load;
      store_pend_reg <= (store_pend_reg || store_take) && !go_store;
      if (load_take) load_base_reg <= load_base_i;
      if (store_take) begin
        store_base_reg <= store_base_i;
        store_data_reg <= res_din_i;
      end
    end
  end

  // Main FSM: walks the BRAM address for loads and stores, emits done pulses.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      addr_reg       <= '0;
      shift_reg      <= '0;
      load_done_reg  <= 1'b0;
      store_done_reg <= 1'b0;
    end else begin
      load_done_reg  <= 1'b0;
      store_done_reg <= 1'b0;
      case (state_reg)
        LOAD_ISSUE: begin
          addr_reg <= addr_reg + ADDR_ONE;
          if (cnt_reg == LOAD_LAST) begin
            state_reg <= LOAD_DRAIN;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        LOAD_DRAIN: begin
          if (at_exit) begin
            load_done_reg <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        STORE: begin
          addr_reg  <= addr_reg + ADDR_ONE;
          shift_reg <= shift_reg >> WORD_WIDTH;
          if (at_exit) begin
            store_done_reg <= 1'b1;
            state_reg      <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        default: ;
      endcase
      if (go_store) begin
        state_reg <= STORE;
        cnt_reg   <= '0;
        addr_reg  <= store_base_next;
        shift_reg <= store_data_next;
      end else if (go_load) begin
        state_reg <= LOAD_ISSUE;
        cnt_reg   <= '0;
        addr_reg  <= load_base_next;
      end
    end
  end

  // Bank selection: swap toggles the active bank, a finished load validates the shadow.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      active_reg       <= 1'b0;
      shadow_valid_reg <= 1'b0;
      swap_err_reg     <= 1'b0;
    end else begin
      swap_err_reg <= swap_i && !swap_ok;
      if ((state_reg == LOAD_DRAIN) && at_exit) shadow_valid_reg <= 1'b1;
      if (swap_ok) begin
        active_reg       <= ~active_reg;
        shadow_valid_reg <= 1'b0;
      end
      // The shadow bank is about to be overwritten, so it is no longer valid.
      if (go_load) shadow_valid_reg <= 1'b0;
    end
  end

  // Read-return alignment: track issued reads through the BRAM latency, then capture.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      vld_pipe_reg  <= '0;
      cap_valid_reg <= 1'b0;
      cap_data_reg  <= '0;
      wr_idx_reg    <= '0;
    end else begin
      vld_pipe_reg  <= (vld_pipe_reg << 1) | BRAM_LAT'(issuing);
      cap_valid_reg <= vld_pipe_reg[BRAM_LAT-1];
      if (vld_pipe_reg[BRAM_LAT-1]) cap_data_reg <= BRAM_dout_i;
      if (cap_valid_reg) wr_idx_reg <= wr_idx_reg + CNT_ONE;
      if (go_load) wr_idx_reg <= '0;
    end
  end

  // Shadow bank write port, fed by the capture register.
  always_ff @(posedge clock_i) begin
    if (cap_valid_reg) mem[{~active_reg, wr_idx_reg}] <= cap_data_reg;
  end

  // Registered active-bank read; out-of-range indices read as zero.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= (rd_addr_i <= LOAD_LAST) ? mem[{active_reg, rd_addr_i}] : '0;
    end
  end

`ifdef POLY_MEMORY_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] checksum_reg;

  // Running XOR of words written to the shadow bank, restarted with each load.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      checksum_reg <= '0;
    end else begin
      if (cap_valid_reg) checksum_reg <= checksum_reg ^ cap_data_reg;
      if (go_load) checksum_reg <= '0;
    end
  end

  assign load_checksum_o = checksum_reg;
`endif

  assign BRAM_en_o      = issuing || (state_reg == STORE);
  assign BRAM_we_o      = (state_reg == STORE);
  assign BRAM_addr_o    = BRAM_en_o ? addr_reg : '0;
  assign BRAM_din_o     = BRAM_we_o ? shift_reg[WORD_WIDTH-1:0] : '0;
  assign rd_data_o      = rd_data_reg;
  assign active_bank_o  = active_reg;
  assign shadow_valid_o = shadow_valid_reg;
  assign busy_o         = (state_reg != IDLE) || load_pend_reg || store_pend_reg;
  assign swap_err_o     = swap_err_reg;
  assign load_done_o    = load_done_reg;
  assign store_done_o   = store_done_reg;

endmodule

// File: tb/tb_poly_memory_pingpong.sv
// Testbench for poly_memory_pingpong: one instance with BRAM_LAT=1 runs the
// load/swap/store/arbitration/reset sequences, a second with BRAM_LAT=3 runs a
// wrapping load (and the checksum when POLY_MEMORY_CHECKSUM_EN is defined).
module tb_poly_memory_pingpong;
  localparam int W  = 17;
  localparam int L  = 80;
  localparam int R  = 20;
  localparam int RA = 7;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A (BRAM_LAT = 1)
  logic          rst_a, a_load_start, a_store_start, a_swap;
  logic [AW-1:0] a_load_base, a_store_base;
  logic [R*W-1:0] a_res_din;
  logic [RA-1:0] a_rd_addr;
  logic [W-1:0]  a_dout;
  logic          a_en, a_we;
  logic [AW-1:0] a_addr;
  logic [W-1:0]  a_din, a_rd_data;
  logic          a_active, a_sv, a_busy, a_serr, a_ldone, a_sdone;

  // Instance B (BRAM_LAT = 3)
  logic          rst_b, b_load_start, b_store_start, b_swap;
  logic [AW-1:0] b_load_base, b_store_base;
  logic [R*W-1:0] b_res_din;
  logic [RA-1:0] b_rd_addr;
  logic [W-1:0]  b_dout, b_d1, b_d2;
  logic          b_en, b_we;
  logic [AW-1:0] b_addr;
  logic [W-1:0]  b_din, b_rd_data;
  logic          b_active, b_sv, b_busy, b_serr, b_ldone, b_sdone;
`ifdef POLY_MEMORY_CHECKSUM_EN
  logic [W-1:0]  a_csum, b_csum;
`endif

  poly_memory_pingpong #(.BRAM_LAT(1)) dut_a (
    .clock_i(clk), .reset_i(rst_a),
    .load_start_i(a_load_start), .load_base_i(a_load_base),
    .store_start_i(a_store_start), .store_base_i(a_store_base),
    .res_din_i(a_res_din), .swap_i(a_swap), .rd_addr_i(a_rd_addr),
    .BRAM_dout_i(a_dout), .BRAM_en_o(a_en), .BRAM_we_o(a_we),
    .BRAM_addr_o(a_addr), .BRAM_din_o(a_din), .rd_data_o(a_rd_data),
    .active_bank_o(a_active), .shadow_valid_o(a_sv), .busy_o(a_busy),
    .swap_err_o(a_serr), .load_done_o(a_ldone), .store_done_o(a_sdone)
`ifdef POLY_MEMORY_CHECKSUM_EN
    , .load_checksum_o(a_csum)
`endif
  );

  poly_memory_pingpong #(.BRAM_LAT(3)) dut_b (
    .clock_i(clk), .reset_i(rst_b),
    .load_start_i(b_load_start), .load_base_i(b_load_base),
    .store_start_i(b_store_start), .store_base_i(b_store_base),
    .res_din_i(b_res_din), .swap_i(b_swap), .rd_addr_i(b_rd_addr),
    .BRAM_dout_i(b_dout), .BRAM_en_o(b_en), .BRAM_we_o(b_we),
    .BRAM_addr_o(b_addr), .BRAM_din_o(b_din), .rd_data_o(b_rd_data),
    .active_bank_o(b_active), .shadow_valid_o(b_sv), .busy_o(b_busy),
    .swap_err_o(b_serr), .load_done_o(b_ldone), .store_done_o(b_sdone)
`ifdef POLY_MEMORY_CHECKSUM_EN
    , .load_checksum_o(b_csum)
`endif
  );

  // BRAM models: single port, 1 and 3 cycles of read latency.
  logic [W-1:0] bram_a [1024];
  logic [W-1:0] bram_b [1024];

  always @(posedge clk) begin
    if (a_en && a_we) bram_a[a_addr] <= a_din;
    if (a_en && !a_we) a_dout <= bram_a[a_addr];
  end

  always @(posedge clk) begin
    if (b_en && b_we) bram_b[b_addr] <= b_din;
    if (b_en && !b_we) b_d1 <= bram_b[b_addr];
    b_d2   <= b_d1;
    b_dout <= b_d2;
  end

  typedef struct {
    logic [RA-1:0] addr;
    logic [W-1:0]  exp;
  } rd_vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rd_vec_t       rd_tbl[10];
    logic [W-1:0]  ref_a [L];
    logic [W-1:0]  ref_b [L];
    logic [W-1:0]  sdata [R];
    logic [W-1:0]  xsum;
    logic [28:0]   exp_bus;
    int            sd_cnt, ld_cnt, sd_cyc, ld_cyc, a;

    rst_a = 1'b1; rst_b = 1'b1;
    a_load_start = 0; a_store_start = 0; a_swap = 0; a_load_base = '0;
    a_store_base = '0; a_res_din = '0; a_rd_addr = '0;
    b_load_start = 0; b_store_start = 0; b_swap = 0; b_load_base = '0;
    b_store_base = '0; b_res_din = '0; b_rd_addr = '0;
    for (int k = 0; k < 1024; k++) begin
      bram_a[k] = '0;
      bram_b[k] = '0;
    end
    tick(); tick();

    // Reset state (checked while reset is held)
    check("reset_bus", {35'd0, a_en, a_we, a_addr, a_din}, 64'd0);
    check("reset_flags", {58'd0, a_active, a_sv, a_busy, a_serr, a_ldone, a_sdone}, 64'd0);
    check("reset_rd_data", {47'd0, a_rd_data}, 64'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // Load from 0x010, BRAM[0x010+k] = k+1
    for (int k = 0; k < L; k++) bram_a[16 + k] = W'(k + 1);
    a_load_start = 1; a_load_base = 10'h010;
    tick();
    a_load_start = 0;
    for (int c = 0; c <= 82; c++) begin
      if (c < L) exp_bus = {1'b1, 1'b0, AW'(16 + c), 17'd0};
      else       exp_bus = '0;
      check("load_bus", {35'd0, a_en, a_we, a_addr, a_din}, {35'd0, exp_bus});
      check("load_done", {63'd0, a_ldone}, {63'd0, (c == 82)});
      check("load_shadow_valid", {63'd0, a_sv}, {63'd0, (c == 82)});
      if (c == 40) check("load_busy", {63'd0, a_busy}, 64'd1);
      if (c < 82) tick();
    end
    $display("txn load base=010 done at cycle 82 expected");

    // Swap in the load_done cycle is rejected, the retry is accepted
    a_swap = 1;
    tick();
    check("swap_at_done_err", {63'd0, a_serr}, 64'd1);
    check("swap_at_done_bank", {63'd0, a_active}, 64'd0);
    tick();
    a_swap = 0;
    check("swap_ok_bank", {63'd0, a_active}, 64'd1);
    check("swap_ok_sv", {63'd0, a_sv}, 64'd0);
    check("swap_ok_err", {63'd0, a_serr}, 64'd0);
    $display("txn swap active_bank=%0d", a_active);

    // Read table over the freshly activated bank
    rd_tbl[0].addr = 7'd37;  rd_tbl[1].addr = 7'd0;   rd_tbl[2].addr = 7'd79;
    rd_tbl[3].addr = 7'd80;  rd_tbl[4].addr = 7'd127; rd_tbl[5].addr = 7'd19;
    rd_tbl[6].addr = 7'd20;
    for (int i = 7; i < 10; i++) rd_tbl[i].addr = RA'($urandom_range(0, 127));
    for (int i = 0; i < 10; i++)
      rd_tbl[i].exp = (int'(rd_tbl[i].addr) < L) ? W'(int'(rd_tbl[i].addr) + 1) : '0;
    for (int i = 0; i < 10; i++) begin
      a_rd_addr = rd_tbl[i].addr;
      tick();
      check("read_table", {47'd0, a_rd_data}, {47'd0, rd_tbl[i].exp});
      $display("txn read addr=%0d data=%0h", rd_tbl[i].addr, a_rd_data);
    end

    // Swap with no valid shadow set
    a_swap = 1;
    tick();
    a_swap = 0;
    check("swap_invalid_err", {63'd0, a_serr}, 64'd1);
    check("swap_invalid_bank", {63'd0, a_active}, 64'd1);
    tick();
    check("swap_err_one_cycle", {63'd0, a_serr}, 64'd0);
    $display("txn swap rejected");

    // Store at 0x3F8 with address wrap
    for (int k = 0; k < R; k++) a_res_din[k*W +: W] = W'(16'h100 + k);
    a_store_start = 1; a_store_base = 10'h3F8;
    tick();
    a_store_start = 0;
    for (int c = 0; c <= R; c++) begin
      if (c < R) exp_bus = {1'b1, 1'b1, AW'(16'h3F8 + c), W'(16'h100 + c)};
      else       exp_bus = '0;
      check("store_bus", {35'd0, a_en, a_we, a_addr, a_din}, {35'd0, exp_bus});
      check("store_done", {63'd0, a_sdone}, {63'd0, (c == R)});
      if (c < R) tick();
    end
    check("store_mem_3ff", {47'd0, bram_a[10'h3FF]}, 64'h107);
    check("store_mem_000", {47'd0, bram_a[10'h000]}, 64'h108);
    check("store_mem_00b", {47'd0, bram_a[10'h00B]}, 64'h113);
    $display("txn store base=3f8 20 words");

    // Simultaneous store and load; a second load start during the store is dropped
    for (int k = 0; k < L; k++) begin
      ref_a[k] = W'($urandom);
      bram_a[10'h300 + k] = ref_a[k];
    end
    for (int k = 0; k < R; k++) begin
      sdata[k] = W'($urandom);
      a_res_din[k*W +: W] = sdata[k];
    end
    a_store_start = 1; a_store_base = 10'h200;
    a_load_start = 1;  a_load_base = 10'h300;
    tick();
    a_store_start = 0; a_load_start = 0;
    sd_cnt = 0; ld_cnt = 0; sd_cyc = -1; ld_cyc = -1;
    for (int c = 0; c <= 110; c++) begin
      if (a_sdone) begin sd_cnt++; sd_cyc = c; end
      if (a_ldone) begin ld_cnt++; ld_cyc = c; end
      if (c < R) begin
        exp_bus = {1'b1, 1'b1, AW'(16'h200 + c), sdata[c]};
        check("both_store_bus", {35'd0, a_en, a_we, a_addr, a_din}, {35'd0, exp_bus});
      end
      if (c == 20) check("both_load_first_addr", {35'd0, a_en, a_we, a_addr, a_din},
                         {35'd0, 1'b1, 1'b0, 10'h300, 17'd0});
      if (c == 60) check("both_busy", {63'd0, a_busy}, 64'd1);
      a_load_start = (c == 5);
      a_load_base  = 10'h100;
      tick();
    end
    a_load_start = 0;
    check("both_store_done_count", 64'(sd_cnt), 64'd1);
    check("both_load_done_count", 64'(ld_cnt), 64'd1);
    check("both_store_done_cycle", 64'(sd_cyc), 64'd20);
    check("both_load_done_cycle", 64'(ld_cyc), 64'd102);
    check("both_idle_busy", {63'd0, a_busy}, 64'd0);
    for (int k = 0; k < R; k++)
      check("both_store_mem", {47'd0, bram_a[10'h200 + k]}, {47'd0, sdata[k]});
    $display("txn store+load store_done=%0d load_done=%0d", sd_cyc, ld_cyc);

    a_swap = 1;
    tick();
    a_swap = 0;
    check("both_swap_bank", {63'd0, a_active}, 64'd0);
    for (int i = 0; i < 16; i++) begin
      a = $urandom_range(0, L - 1);
      a_rd_addr = RA'(a);
      tick();
      check("both_random_read", {47'd0, a_rd_data}, {47'd0, ref_a[a]});
      $display("txn read addr=%0d data=%0h", a, a_rd_data);
    end

    // Reset in load cycle 40
    a_load_start = 1; a_load_base = 10'h000;
    tick();
    a_load_start = 0;
    for (int c = 0; c < 40; c++) tick();
    rst_a = 1'b1;
    #1;
    check("rst_mid_bus", {63'd0, a_en}, 64'd0);
    check("rst_mid_flags", {60'd0, a_active, a_sv, a_busy, a_ldone}, 64'd0);
    tick(); tick();
    rst_a = 1'b0;
    ld_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (a_ldone || a_sv || a_en) ld_cnt++;
      tick();
    end
    check("rst_mid_no_done", 64'(ld_cnt), 64'd0);
    $display("txn reset during load");

    // Instance B: BRAM_LAT=3, load from 0x3E0 (wraps)
    xsum = '0;
    for (int k = 0; k < L; k++) begin
      ref_b[k] = W'($urandom);
      bram_b[AW'(16'h3E0 + k)] = ref_b[k];
      xsum ^= ref_b[k];
    end
    b_load_start = 1; b_load_base = 10'h3E0;
    tick();
    b_load_start = 0;
    for (int c = 0; c <= 84; c++) begin
      if (c < L) exp_bus = {1'b1, 1'b0, AW'(16'h3E0 + c), 17'd0};
      else       exp_bus = '0;
      check("lat3_bus", {35'd0, b_en, b_we, b_addr, b_din}, {35'd0, exp_bus});
      check("lat3_done", {63'd0, b_ldone}, {63'd0, (c == 84)});
`ifdef POLY_MEMORY_CHECKSUM_EN
      if (c == 84) check("lat3_checksum", {47'd0, b_csum}, {47'd0, xsum});
`endif
      if (c < 84) tick();
    end
    tick();
    b_swap = 1;
    tick();
    b_swap = 0;
    check("lat3_swap_bank", {63'd0, b_active}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, L - 1);
      b_rd_addr = RA'(a);
      tick();
      check("lat3_random_read", {47'd0, b_rd_data}, {47'd0, ref_b[a]});
    end
    $display("txn lat3 load base=3e0 checksum=%0h", xsum);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
